// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register.
// Drives a req/ready imem port, parks stalled responses, drains on redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        pcsrcE,
  input  logic [31:0] pcTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic [31:0] pcPlus4D,
  output logic        validD,
  output logic        fetchBusy
);

  typedef enum logic {FETCH, DRAIN} state_t;

  state_t      state, state_n;
  logic [31:0] pcF, reqAddr;
  logic [31:0] holdInstr, holdPc;
  logic        holdValid;
  logic [31:0] target;
  logic        xfer, fxfer;
  logic        capture, park, unhold;

  assign target = pcTargetE & ~32'h3;

  always_comb begin
    state_n   = state;
    imem_req  = 1'b0;
    imem_addr = pcF;
    fetchBusy = 1'b0;
    unique case (state)
      FETCH: begin
        imem_req  = !rst && !holdValid;
        fetchBusy = imem_req && !imem_ready;
        if (pcsrcE && imem_req && !imem_ready)
          state_n = DRAIN;
      end
      DRAIN: begin
        imem_req  = !rst;
        imem_addr = reqAddr;
        fetchBusy = 1'b1;
        if (imem_ready)
          state_n = FETCH;
      end
      default: state_n = FETCH;
    endcase
  end

  assign xfer    = imem_req && imem_ready;
  // Only FETCH-state transfers are kept, and not under a redirect
  assign fxfer   = (state == FETCH) && xfer && !pcsrcE;
  assign capture = fxfer && !stallF && !stallD;
  assign park    = fxfer && (stallF || stallD);
  assign unhold  = holdValid && !stallD && !pcsrcE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FETCH;
      pcF       <= RESET_PC;
      reqAddr   <= RESET_PC;
      holdValid <= 1'b0;
      holdInstr <= NOP_INSTR;
      holdPc    <= RESET_PC;
    end else begin
      state <= state_n;
      if (state == FETCH && state_n == DRAIN)
        reqAddr <= pcF;
      if (pcsrcE)
        pcF <= target;
      else if (fxfer)
        pcF <= pcF + 32'd4;
      if (park) begin
        holdInstr <= imem_rdata;
        holdPc    <= pcF;
      end
      if (pcsrcE)
        holdValid <= 1'b0;
      else if (park)
        holdValid <= 1'b1;
      else if (unhold)
        holdValid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instrD   <= NOP_INSTR;
      pcD      <= 32'h0;
      pcPlus4D <= 32'h0;
      validD   <= 1'b0;
    end else if (flushD) begin
      instrD <= NOP_INSTR;
      validD <= 1'b0;
    end else if (!stallD) begin
      if (capture) begin
        instrD   <= imem_rdata;
        pcD      <= pcF;
        pcPlus4D <= pcF + 32'd4;
        validD   <= 1'b1;
      end else if (unhold) begin
        instrD   <= holdInstr;
        pcD      <= holdPc;
        pcPlus4D <= holdPc + 32'd4;
        validD   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed vector bench for fetch_stage.
// Memory returns addr + 0x1000_0000 so each fetch is identifiable.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallF, stallD, flushD, pcsrcE;
  logic [31:0] pcTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instrD, pcD, pcPlus4D;
  logic        validD, fetchBusy;

  int compared = 0;
  int mismatched = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst),
    .stallF(stallF), .stallD(stallD),
    .flushD(flushD), .pcsrcE(pcsrcE),
    .pcTargetE(pcTargetE),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instrD(instrD), .pcD(pcD), .pcPlus4D(pcPlus4D),
    .validD(validD), .fetchBusy(fetchBusy)
  );

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr + 32'h1000_0000;

  typedef struct {
    logic        sf, sd, fl, pc;
    logic [31:0] tgt;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        busy;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic        vld;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(
    logic sf, logic sd, logic fl, logic pc,
    logic [31:0] tgt, logic rdy, logic req,
    logic [31:0] addr, logic busy,
    logic [31:0] instr, logic [31:0] pcd, logic vld);
    vec_t v;
    v.sf = sf; v.sd = sd; v.fl = fl; v.pc = pc;
    v.tgt = tgt; v.rdy = rdy; v.req = req;
    v.addr = addr; v.busy = busy;
    v.instr = instr; v.pcd = pcd; v.vld = vld;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    rst = 1'b1;
    stallF = 0; stallD = 0; flushD = 0; pcsrcE = 0;
    pcTargetE = 0; imem_ready = 0;

    // sf sd fl pc tgt rdy | req addr busy | instr pcD vld
    vt.push_back(mk(0,0,0,0,0,1, 1,32'h0,0, 32'h1000_0000,32'h0,1));
    vt.push_back(mk(0,0,0,0,0,1, 1,32'h4,0, 32'h1000_0004,32'h4,1));
    vt.push_back(mk(0,0,0,0,0,1, 1,32'h8,0, 32'h1000_0008,32'h8,1));
    vt.push_back(mk(0,0,0,0,0,0, 1,32'hC,1, 32'h1000_0008,32'h8,1));
    vt.push_back(mk(0,0,0,0,0,0, 1,32'hC,1, 32'h1000_0008,32'h8,1));
    vt.push_back(mk(0,0,0,0,0,1, 1,32'hC,0, 32'h1000_000C,32'hC,1));
    vt.push_back(mk(0,1,0,0,0,1, 1,32'h10,0, 32'h1000_000C,32'hC,1));
    vt.push_back(mk(0,1,0,0,0,1, 0,32'h14,0, 32'h1000_000C,32'hC,1));
    vt.push_back(mk(0,1,0,0,0,1, 0,32'h14,0, 32'h1000_000C,32'hC,1));
    vt.push_back(mk(0,0,0,0,0,1, 0,32'h14,0, 32'h1000_0010,32'h10,1));
    vt.push_back(mk(0,0,0,0,0,1, 1,32'h14,0, 32'h1000_0014,32'h14,1));
    vt.push_back(mk(0,0,0,0,0,1, 1,32'h18,0, 32'h1000_0018,32'h18,1));
    vt.push_back(mk(0,0,0,0,0,1, 1,32'h1C,0, 32'h1000_001C,32'h1C,1));
    vt.push_back(mk(0,0,0,0,0,0, 1,32'h20,1, 32'h1000_001C,32'h1C,1));
    vt.push_back(mk(0,0,1,1,32'h100,0, 1,32'h20,1, 32'h13,32'h1C,0));
    vt.push_back(mk(0,0,0,0,0,0, 1,32'h20,1, 32'h13,32'h1C,0));
    vt.push_back(mk(0,0,0,0,0,1, 1,32'h20,1, 32'h13,32'h1C,0));
    vt.push_back(mk(0,0,0,0,0,1, 1,32'h100,0, 32'h1000_0100,32'h100,1));
    vt.push_back(mk(0,0,1,1,32'hFFFF_FFFF,1, 1,32'h104,0, 32'h13,32'h100,0));
    vt.push_back(mk(0,0,0,0,0,1, 1,32'hFFFF_FFFC,0, 32'h0FFF_FFFC,32'hFFFF_FFFC,1));
    vt.push_back(mk(0,0,0,0,0,1, 1,32'h0,0, 32'h1000_0000,32'h0,1));
    vt.push_back(mk(0,0,0,0,0,0, 1,32'h4,1, 32'h1000_0000,32'h0,1));
    vt.push_back(mk(0,0,1,1,32'h200,0, 1,32'h4,1, 32'h13,32'h0,0));
    vt.push_back(mk(0,0,0,1,32'h300,0, 1,32'h4,1, 32'h13,32'h0,0));
    vt.push_back(mk(0,0,0,0,0,1, 1,32'h4,1, 32'h13,32'h0,0));
    vt.push_back(mk(0,0,0,0,0,1, 1,32'h300,0, 32'h1000_0300,32'h300,1));
    vt.push_back(mk(0,0,0,0,0,0, 1,32'h304,1, 32'h1000_0300,32'h300,1));
    vt.push_back(mk(0,0,1,1,32'h40,0, 1,32'h304,1, 32'h13,32'h300,0));

    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_busy", {31'b0, fetchBusy}, 32'h0);
    chk("rst_instr", instrD, 32'h13);
    chk("rst_pcD", pcD, 32'h0);
    chk("rst_pc4", pcPlus4D, 32'h0);
    chk("rst_valid", {31'b0, validD}, 32'h0);

    foreach (vt[i]) begin
      @(negedge clk);
      if (i == 0) rst = 1'b0;
      stallF = vt[i].sf; stallD = vt[i].sd;
      flushD = vt[i].fl; pcsrcE = vt[i].pc;
      pcTargetE = vt[i].tgt; imem_ready = vt[i].rdy;
      #1;
      chk($sformatf("v%0d_req", i), {31'b0, imem_req}, {31'b0, vt[i].req});
      chk($sformatf("v%0d_addr", i), imem_addr, vt[i].addr);
      chk($sformatf("v%0d_busy", i), {31'b0, fetchBusy}, {31'b0, vt[i].busy});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_instr", i), instrD, vt[i].instr);
      chk($sformatf("v%0d_pcD", i), pcD, vt[i].pcd);
      chk($sformatf("v%0d_pc4", i), pcPlus4D, vt[i].pcd + 32'd4);
      chk($sformatf("v%0d_valid", i), {31'b0, validD}, {31'b0, vt[i].vld});
    end

    // Reset while draining a redirected fetch
    @(negedge clk);
    rst = 1'b1;
    stallF = 0; stallD = 0; flushD = 0; pcsrcE = 0;
    pcTargetE = 0; imem_ready = 0;
    #1;
    chk("drst_req", {31'b0, imem_req}, 32'h0);
    chk("drst_addr", imem_addr, 32'h0);
    chk("drst_busy", {31'b0, fetchBusy}, 32'h0);
    chk("drst_instr", instrD, 32'h13);
    chk("drst_valid", {31'b0, validD}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    imem_ready = 1'b1;
    #1;
    chk("post_req", {31'b0, imem_req}, 32'h1);
    chk("post_addr", imem_addr, 32'h0);
    @(posedge clk);
    #1;
    chk("post_instr", instrD, 32'h1000_0000);
    chk("post_pcD", pcD, 32'h0);
    chk("post_valid", {31'b0, validD}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the pipelined core.
- Consumes the stall, flush and redirect controls that the hazard unit produces: stallF, stallD, flushD, and pcsrcE with its target.
- Drives a request/ready instruction-memory port that may take multiple cycles per fetch.
- Reports fetchBusy so the hazard unit can freeze the pipeline while a fetch is outstanding.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, instruction placed in IF/ID on flush or reset (addi x0,x0,0)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
stallF  in  1  hold PC and block PC advance
stallD  in  1  hold IF/ID register contents
flushD  in  1  replace IF/ID with NOP at next edge
pcsrcE  in  1  redirect fetch to pcTargetE (taken branch/jump resolved in EX)
pcTargetE  in  32  redirect target
imem_req  out  1  instruction-memory request valid
imem_addr  out  32  word address of request (byte address, bits[1:0]=0)
imem_ready  in  1  memory accepts request and returns imem_rdata this cycle
imem_rdata  in  32  fetched instruction, valid when imem_req && imem_ready
instrD  out  32  IF/ID instruction
pcD  out  32  IF/ID PC
pcPlus4D  out  32  IF/ID PC+4
validD  out  1  IF/ID holds a real (non-bubble) instruction
fetchBusy  out  1  fetch outstanding; hazard unit must stall

Behaviour:
Reset (asynchronous, immediate on rst):
- pcF=RESET_PC; state=FETCH; holdValid=0.
- instrD=NOP_INSTR, pcD=0, pcPlus4D=0, validD=0.
- imem_req is 0 while rst is high.

Transfer rule:
- A transfer completes in a cycle with imem_req && imem_ready. Memory responds in the same cycle; zero-wait memory gives 1 instruction/cycle.
- Once raised, imem_req and imem_addr stay stable until a transfer completes. Requests are never aborted.

State FETCH:
- imem_req = !holdValid; imem_addr = pcF.
- On transfer with !stallF and !stallD: IF/ID <= {imem_rdata, pcF, pcF+4, validD=1}; pcF <= pcF+4.
- On transfer with stallD=1: response goes to the hold buffer (holdInstr, holdPc); holdValid=1; pcF <= pcF+4. No new request is issued while holdValid=1.
- When holdValid=1 and stallD=0: IF/ID <= hold buffer, validD=1; holdValid <= 0. A new request is issued the following cycle.
- stallF=1 with no transfer: pcF is held.

Redirect (pcsrcE=1) has top priority over stall and fetch advance:
- pcF <= pcTargetE; holdValid <= 0.
- If a request is outstanding this cycle without imem_ready: latch reqAddr=pcF, go to DRAIN.
- If the transfer completes this same cycle, its data is discarded and the state stays FETCH.

State DRAIN:
- imem_req=1; imem_addr=reqAddr.
- On imem_ready: data discarded, go to FETCH.
- A further pcsrcE while in DRAIN updates pcF only.

Flush (flushD=1) at the edge:
- instrD=NOP_INSTR, validD=0; pcD and pcPlus4D unchanged.
- flushD overrides stallD and any capture.

fetchBusy:
- 1 when (state==FETCH && imem_req && !imem_ready) or state==DRAIN; else 0.
- Combinational.

Arithmetic:
- pcF+4 wraps modulo 2^32 (0xFFFF_FFFC+4 = 0).
- pcTargetE[1:0] is forced to 0.

Test Plan:
- Zero-wait memory (imem_ready=1), rdata=PC-derived, release rst -> imem_addr 0,4,8,… on consecutive cycles; pcD trails imem_addr by 1 cycle; validD=1 from 1st edge after rst drops.
- Memory with 2 wait cycles per fetch -> fetchBusy=1 for 2 cycles per fetch, imem_addr stable across waits, instrD updates every 3rd cycle.
- Transfer at addr 0x10 while stallD=1 for 3 cycles -> IF/ID keeps 0x0C, no imem_req during stall; when stallD drops, instrD=data@0x10 and next request is 0x14.
- pcsrcE=1, pcTargetE=0x100, flushD=1 during a waited fetch of 0x20 -> state DRAIN, imem_addr stays 0x20 until ready, that data is dropped, next request is 0x100; instrD=0x00000013, validD=0.
- Assert rst mid-DRAIN -> imem_req=0, pcF=RESET_PC, validD=0 immediately; first request after release is RESET_PC.
- pcTargetE=0xFFFF_FFFC -> next fetch addresses are 0xFFFF_FFFC then 0x0000_0000.
